// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: free-list sizing helpers, the preg index
// type and the prefix popcount used to compact lanes.
package rename_pkg;

    // Pregs 0..31 hold the initial architectural mappings; the rest are free.
    function automatic int calc_fl_depth(input int phy_reg_num);
        return phy_reg_num - 32;
    endfunction

    function automatic int calc_preg_w(input int phy_reg_num);
        return $clog2(phy_reg_num);
    endfunction

    localparam int PHY_REG_NUM_DEF = 64;
    localparam int PREG_W_DEF      = calc_preg_w(PHY_REG_NUM_DEF);

    typedef logic [PREG_W_DEF-1:0] preg_t;

    // Widest lane vector the popcount helper accepts.
    localparam int POPCNT_MAX_W = 32;

    // Number of set bits in vec[i-1:0]; i = 0 gives 0.
    function automatic logic [5:0] prefix_popcnt(input logic [POPCNT_MAX_W-1:0] vec,
                                                 input int i);
        logic [5:0] cnt;
        cnt = '0;
        for (int j = 0; j < POPCNT_MAX_W; j++) begin
            if (j < i) begin
                cnt = cnt + {5'b0, vec[j]};
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename/commit side bundle of the free list: allocation request, offered
// pregs, commit frees, flush and the registered free count.
interface free_list_if #(
    parameter int DECODE_WIDTH = 4,
    parameter int COMMIT_WIDTH = 4,
    parameter int PREG_W       = 6,
    parameter int CNT_W        = 6
);
    logic [DECODE_WIDTH-1:0]             alloc_valid_i;
    logic                                alloc_ready_o;
    logic [DECODE_WIDTH-1:0][PREG_W-1:0] preg_o;
    logic [COMMIT_WIDTH-1:0]             free_i;
    logic [COMMIT_WIDTH-1:0][PREG_W-1:0] old_preg_i;
    logic                                restore_i;
    logic [CNT_W-1:0]                    free_cnt_o;

    // Rename/commit logic driving the free list.
    modport master (
        output alloc_valid_i, free_i, old_preg_i, restore_i,
        input  alloc_ready_o, preg_o, free_cnt_o
    );

    // The free list itself.
    modport slave (
        input  alloc_valid_i, free_i, old_preg_i, restore_i,
        output alloc_ready_o, preg_o, free_cnt_o
    );
endinterface

// File: rtl/free_list_compactor.sv
// Prefix-popcount offset generator: lane i gets the number of valid lanes
// below it, so valid lanes map onto consecutive list slots.
module free_list_compactor
    import rename_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]            vec_i,
    output logic [WIDTH-1:0][CNT_W-1:0] offset_o,
    output logic [CNT_W-1:0]            total_o
);

    if (WIDTH > POPCNT_MAX_W) begin : g_width_check
        $error("free_list_compactor: WIDTH exceeds prefix_popcnt range");
    end

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
        // Offset of this lane among the valid lanes.
        assign offset_o[gi] = CNT_W'(prefix_popcnt(POPCNT_MAX_W'(vec_i), gi));
    end

    // Total valid lanes = prefix count over the whole vector.
    assign total_o = CNT_W'(prefix_popcnt(POPCNT_MAX_W'(vec_i), WIDTH));

endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers for the rename stage. Hands out
// up to DECODE_WIDTH pregs per cycle, takes back up to COMMIT_WIDTH retired
// pregs per cycle, and rolls the speculative head back to the committed head
// on a flush.
module free_list
    import rename_pkg::*;
#(
    parameter int PHY_REG_NUM  = 64,
    parameter int DECODE_WIDTH = 4,
    parameter int COMMIT_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    free_list_if.slave  fl
);

    localparam int FL_DEPTH = calc_fl_depth(PHY_REG_NUM);
    localparam int PREG_W   = calc_preg_w(PHY_REG_NUM);
    localparam int PTR_W    = $clog2(FL_DEPTH);
    localparam int ACNT_W   = $clog2(DECODE_WIDTH + 1);
    localparam int FCNT_W   = $clog2(COMMIT_WIDTH + 1);

    typedef logic [PTR_W:0]    ptr_t;
    typedef logic [PTR_W-1:0]  idx_t;
    typedef logic [PREG_W-1:0] preg_idx_t;

    localparam ptr_t DEPTH_CNT = ptr_t'(FL_DEPTH);
    localparam ptr_t DW_CNT    = ptr_t'(DECODE_WIDTH);

    // Pointer arithmetic relies on the depth being a power of two.
    if ((FL_DEPTH < 2) || ((FL_DEPTH & (FL_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("free_list: PHY_REG_NUM-32 must be a power of two");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    preg_idx_t fl_q [FL_DEPTH];
    preg_idx_t fl_d [FL_DEPTH];
    ptr_t      head_q, head_d;
    ptr_t      arch_head_q, arch_head_d;
    ptr_t      tail_q, tail_d;

    // ------------------------------------------------------------------
    // Lane compaction
    // ------------------------------------------------------------------
    logic [DECODE_WIDTH-1:0][ACNT_W-1:0] alloc_off;
    logic [ACNT_W-1:0]                   alloc_total;
    logic [COMMIT_WIDTH-1:0][FCNT_W-1:0] free_off;
    logic [FCNT_W-1:0]                   free_total;

    free_list_compactor #(
        .WIDTH (DECODE_WIDTH),
        .CNT_W (ACNT_W)
    ) u_alloc_cmp (
        .vec_i    (fl.alloc_valid_i),
        .offset_o (alloc_off),
        .total_o  (alloc_total)
    );

    free_list_compactor #(
        .WIDTH (COMMIT_WIDTH),
        .CNT_W (FCNT_W)
    ) u_free_cmp (
        .vec_i    (fl.free_i),
        .offset_o (free_off),
        .total_o  (free_total)
    );

    // ------------------------------------------------------------------
    // Status and allocation
    // ------------------------------------------------------------------
    ptr_t free_cnt;
    logic alloc_ready;
    logic alloc_fire;

    // Count and ready come only from registered pointers, so there is no
    // valid->ready combinational path.
    always_comb begin
        free_cnt    = tail_q - head_q;
        alloc_ready = (free_cnt >= DW_CNT);
        alloc_fire  = alloc_ready && (|fl.alloc_valid_i) && !fl.restore_i;
    end

    assign fl.free_cnt_o    = free_cnt;
    assign fl.alloc_ready_o = alloc_ready;

    // Offer compacted pregs from the head every cycle, firing or not.
    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            fl.preg_o[i] = fl_q[idx_t'(head_q[PTR_W-1:0] + idx_t'(alloc_off[i]))];
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    // Pointer update: frees always advance tail and arch head; a flush
    // snaps head to the arch head including this cycle's commits.
    always_comb begin
        arch_head_d = arch_head_q + ptr_t'(free_total);
        tail_d      = tail_q + ptr_t'(free_total);
        head_d      = head_q;
        if (fl.restore_i) begin
            head_d = arch_head_d;
        end else if (alloc_fire) begin
            head_d = head_q + ptr_t'(alloc_total);
        end
    end

    // Write retired pregs at the tail; they become readable next cycle.
    always_comb begin
        fl_d = fl_q;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (fl.free_i[i]) begin
                fl_d[idx_t'(tail_q[PTR_W-1:0] + idx_t'(free_off[i]))] = fl.old_preg_i[i];
            end
        end
    end

    // Pointer registers; reset leaves the list full.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= DEPTH_CNT;
        end else begin
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
        end
    end

    genvar gi;
    for (gi = 0; gi < FL_DEPTH; gi++) begin : g_entry
        // List entry; reset fills it with the non-architectural pregs.
        always_ff @(posedge clk) begin
            if (rst) begin
                fl_q[gi] <= preg_idx_t'(32 + gi);
            end else begin
                fl_q[gi] <= fl_d[gi];
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    ptr_t count_next;
    ptr_t uncommitted;
    assign count_next  = tail_d - head_d;
    assign uncommitted = head_q - arch_head_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        count_next <= DEPTH_CNT)
        else $error("free_list: free count overflow");

    a_free_bound: assert property (@(posedge clk) disable iff (rst)
        ptr_t'(free_total) <= uncommitted)
        else $error("free_list: more frees than uncommitted allocations");
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list with 64 pregs, 4 decode and 4 commit lanes.
module tb_free_list;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc;

    free_list_if #(
        .DECODE_WIDTH (4),
        .COMMIT_WIDTH (4),
        .PREG_W       (6),
        .CNT_W        (6)
    ) fl_if ();

    free_list #(
        .PHY_REG_NUM  (64),
        .DECODE_WIDTH (4),
        .COMMIT_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; inputs driven and outputs sampled 1ns after the edge.
    task automatic tick();
        $display("cyc %0d: rst=%b alloc=%b free=%b restore=%b cnt=%0d ready=%b",
                 cyc, rst, fl_if.alloc_valid_i, fl_if.free_i, fl_if.restore_i,
                 fl_if.free_cnt_o, fl_if.alloc_ready_o);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        fl_if.alloc_valid_i = '0;
        fl_if.free_i        = '0;
        fl_if.old_preg_i    = '0;
        fl_if.restore_i     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Scenario 1: reset values and a full-width first allocation.
    task automatic test_reset();
        do_reset();
        n_cmp++; if (fl_if.free_cnt_o !== 6'd32) begin n_err++; $display("FAIL reset_cnt got %0d want 32", fl_if.free_cnt_o); end
        n_cmp++; if (fl_if.alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", fl_if.alloc_ready_o); end
        fl_if.alloc_valid_i = 4'b1111;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (fl_if.preg_o[i] !== 6'(32 + i)) begin
                n_err++; $display("FAIL reset_preg%0d got %0d want %0d", i, fl_if.preg_o[i], 32 + i);
            end
        end
        tick();
        fl_if.alloc_valid_i = '0;
        n_cmp++; if (fl_if.free_cnt_o !== 6'd28) begin n_err++; $display("FAIL reset_alloc_cnt got %0d want 28", fl_if.free_cnt_o); end
    endtask

    // Scenario 2: sparse lanes are compacted onto consecutive entries.
    task automatic test_compaction();
        do_reset();
        fl_if.alloc_valid_i = 4'b1010;
        #1;
        n_cmp++; if (fl_if.preg_o[1] !== 6'd32) begin n_err++; $display("FAIL cmp_lane1 got %0d want 32", fl_if.preg_o[1]); end
        n_cmp++; if (fl_if.preg_o[3] !== 6'd33) begin n_err++; $display("FAIL cmp_lane3 got %0d want 33", fl_if.preg_o[3]); end
        tick();
        fl_if.alloc_valid_i = '0;
        n_cmp++; if (fl_if.free_cnt_o !== 6'd30) begin n_err++; $display("FAIL cmp_cnt got %0d want 30", fl_if.free_cnt_o); end
        fl_if.alloc_valid_i = 4'b0001;
        #1;
        n_cmp++; if (fl_if.preg_o[0] !== 6'd34) begin n_err++; $display("FAIL cmp_next got %0d want 34", fl_if.preg_o[0]); end
        fl_if.alloc_valid_i = '0;
    endtask

    // Scenario 3: drain to empty, then a held request must not move head.
    task automatic test_drain();
        do_reset();
        fl_if.alloc_valid_i = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp++; if (fl_if.free_cnt_o !== 6'(32 - 4*c)) begin n_err++; $display("FAIL drain_cnt%0d got %0d want %0d", c, fl_if.free_cnt_o, 32 - 4*c); end
            n_cmp++; if (fl_if.alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL drain_ready%0d got %b want 1", c, fl_if.alloc_ready_o); end
            n_cmp++; if (fl_if.preg_o[0] !== 6'(32 + 4*c)) begin n_err++; $display("FAIL drain_preg%0d got %0d want %0d", c, fl_if.preg_o[0], 32 + 4*c); end
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            n_cmp++; if (fl_if.free_cnt_o !== 6'd0) begin n_err++; $display("FAIL empty_cnt%0d got %0d want 0", c, fl_if.free_cnt_o); end
            n_cmp++; if (fl_if.alloc_ready_o !== 1'b0) begin n_err++; $display("FAIL empty_ready%0d got %b want 0", c, fl_if.alloc_ready_o); end
            n_cmp++; if (fl_if.preg_o[0] !== 6'd32) begin n_err++; $display("FAIL empty_head%0d got %0d want 32", c, fl_if.preg_o[0]); end
            tick();
        end
        fl_if.alloc_valid_i = '0;
    endtask

    // Scenario 4: refill an empty list; runs straight after test_drain.
    task automatic test_free_at_empty();
        fl_if.free_i        = 4'b0101;
        fl_if.old_preg_i[0] = 6'd5;
        fl_if.old_preg_i[1] = 6'd7;
        fl_if.old_preg_i[2] = 6'd9;
        fl_if.old_preg_i[3] = 6'd7;
        tick();
        clear_inputs();
        n_cmp++; if (fl_if.free_cnt_o !== 6'd2) begin n_err++; $display("FAIL refill_cnt2 got %0d want 2", fl_if.free_cnt_o); end
        n_cmp++; if (fl_if.alloc_ready_o !== 1'b0) begin n_err++; $display("FAIL refill_ready2 got %b want 0", fl_if.alloc_ready_o); end
        fl_if.free_i        = 4'b0011;
        fl_if.old_preg_i[0] = 6'd11;
        fl_if.old_preg_i[1] = 6'd12;
        tick();
        clear_inputs();
        n_cmp++; if (fl_if.free_cnt_o !== 6'd4) begin n_err++; $display("FAIL refill_cnt4 got %0d want 4", fl_if.free_cnt_o); end
        n_cmp++; if (fl_if.alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL refill_ready4 got %b want 1", fl_if.alloc_ready_o); end
        fl_if.alloc_valid_i = 4'b1000;
        #1;
        n_cmp++; if (fl_if.preg_o[3] !== 6'd5) begin n_err++; $display("FAIL refill_preg got %0d want 5", fl_if.preg_o[3]); end
        tick();
        fl_if.alloc_valid_i = 4'b0011;
        #1;
        n_cmp++; if (fl_if.free_cnt_o !== 6'd3) begin n_err++; $display("FAIL refill_cnt3 got %0d want 3", fl_if.free_cnt_o); end
        n_cmp++; if (fl_if.preg_o[0] !== 6'd9) begin n_err++; $display("FAIL refill_p0 got %0d want 9", fl_if.preg_o[0]); end
        n_cmp++; if (fl_if.preg_o[1] !== 6'd11) begin n_err++; $display("FAIL refill_p1 got %0d want 11", fl_if.preg_o[1]); end
        clear_inputs();
    endtask

    // Simultaneous alloc and free; freed entries are not offered the same cycle.
    task automatic test_back_to_back();
        do_reset();
        fl_if.alloc_valid_i = 4'b1111;
        tick();
        fl_if.free_i = 4'b1111;
        for (int i = 0; i < 4; i++) fl_if.old_preg_i[i] = 6'(i + 1);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (fl_if.preg_o[i] !== 6'(36 + i)) begin
                n_err++; $display("FAIL b2b_preg%0d got %0d want %0d", i, fl_if.preg_o[i], 36 + i);
            end
        end
        tick();
        clear_inputs();
        n_cmp++; if (fl_if.free_cnt_o !== 6'd28) begin n_err++; $display("FAIL b2b_cnt got %0d want 28", fl_if.free_cnt_o); end
    endtask

    // Scenario 5: restore with same-cycle commit and a suppressed allocation.
    task automatic test_restore();
        do_reset();
        fl_if.alloc_valid_i = 4'b1111;
        tick(); tick(); tick();
        n_cmp++; if (fl_if.free_cnt_o !== 6'd20) begin n_err++; $display("FAIL rst_pre_cnt got %0d want 20", fl_if.free_cnt_o); end
        fl_if.free_i    = 4'b1111;
        for (int i = 0; i < 4; i++) fl_if.old_preg_i[i] = 6'(i);
        fl_if.restore_i = 1'b1;
        tick();
        clear_inputs();
        n_cmp++; if (fl_if.free_cnt_o !== 6'd32) begin n_err++; $display("FAIL restore_cnt got %0d want 32", fl_if.free_cnt_o); end
        n_cmp++; if (fl_if.alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL restore_ready got %b want 1", fl_if.alloc_ready_o); end
        fl_if.alloc_valid_i = 4'b0001;
        #1;
        n_cmp++; if (fl_if.preg_o[0] !== 6'd36) begin n_err++; $display("FAIL restore_preg got %0d want 36", fl_if.preg_o[0]); end
        clear_inputs();
    endtask

    // Scenario 6: reset wins over alloc, free and restore in one cycle.
    task automatic test_reset_mid();
        do_reset();
        fl_if.alloc_valid_i = 4'b1111;
        tick(); tick();
        fl_if.free_i        = 4'b0011;
        fl_if.old_preg_i[0] = 6'd1;
        fl_if.old_preg_i[1] = 6'd2;
        fl_if.restore_i     = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        n_cmp++; if (fl_if.free_cnt_o !== 6'd32) begin n_err++; $display("FAIL midrst_cnt got %0d want 32", fl_if.free_cnt_o); end
        n_cmp++; if (fl_if.alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", fl_if.alloc_ready_o); end
        fl_if.alloc_valid_i = 4'b1111;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (fl_if.preg_o[i] !== 6'(32 + i)) begin
                n_err++; $display("FAIL midrst_preg%0d got %0d want %0d", i, fl_if.preg_o[i], 32 + i);
            end
        end
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b1;
        clear_inputs();
        #2;
        test_reset();
        test_compaction();
        test_drain();
        test_free_at_empty();
        test_back_to_back();
        test_restore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
